// File: rtl/cpu_pkg.sv
// Shared CPU datapath widths and ALU operation encodings.
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUCTRL_W  = 3;

  localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b111;

  function automatic logic is_alu_op(input logic [ALUCTRL_W-1:0] op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
           (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: EX/MEM beats MEM/WB, register 0 is never forwarded.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int FWD_DATA_W = DATA_W,
  parameter int FWD_ADDR_W = REG_ADDR_W
) (
  input  logic [FWD_ADDR_W-1:0] src_addr_i,
  input  logic [FWD_DATA_W-1:0] held_data_i,
  input  logic                  exm_reg_write_i,
  input  logic [FWD_ADDR_W-1:0] exm_write_reg_i,
  input  logic [FWD_DATA_W-1:0] exm_result_i,
  input  logic                  wb_reg_write_i,
  input  logic [FWD_ADDR_W-1:0] wb_write_reg_i,
  input  logic [FWD_DATA_W-1:0] wb_result_i,
  output logic [FWD_DATA_W-1:0] fwd_data_o
);

  logic exm_hit;
  logic wb_hit;

  assign exm_hit = exm_reg_write_i && (exm_write_reg_i != '0) && (exm_write_reg_i == src_addr_i);
  assign wb_hit  = wb_reg_write_i  && (wb_write_reg_i  != '0) && (wb_write_reg_i  == src_addr_i);

  always_comb begin
    fwd_data_o = held_data_i;
    if (exm_hit) begin
      fwd_data_o = exm_result_i;
    end else if (wb_hit) begin
      fwd_data_o = wb_result_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding into the ALU.
// Build option: ID_EX_SKID_EN adds a one-entry skid buffer so in_ready is registered.
module id_ex_stage #(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int ALUCTRL_W  = cpu_pkg::ALUCTRL_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_rs_data,
  input  logic [DATA_W-1:0]     in_rt_data,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic [REG_ADDR_W-1:0] in_rs,
  input  logic [REG_ADDR_W-1:0] in_rt,
  input  logic                  in_alu_src,
  input  logic [ALUCTRL_W-1:0]  in_alu_control,
  input  logic                  exm_reg_write,
  input  logic [REG_ADDR_W-1:0] exm_write_reg,
  input  logic [DATA_W-1:0]     exm_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_write_reg,
  input  logic [DATA_W-1:0]     wb_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     num1,
  output logic [DATA_W-1:0]     num2,
  output logic [ALUCTRL_W-1:0]  alu_control,
  output logic [DATA_W-1:0]     store_data
);

  localparam int ENT_W = 3*DATA_W + 2*REG_ADDR_W + 1 + ALUCTRL_W;

  logic [ENT_W-1:0]      in_entry;
  logic [ENT_W-1:0]      main_q, main_d;
  logic                  out_valid_q, out_valid_d;
  logic                  load;

  logic [DATA_W-1:0]     m_rs_data, m_rt_data, m_imm;
  logic [REG_ADDR_W-1:0] m_rs, m_rt;
  logic                  m_alu_src;
  logic [ALUCTRL_W-1:0]  m_alu_control;

  assign in_entry = {in_rs_data, in_rt_data, in_imm, in_rs, in_rt, in_alu_src, in_alu_control};
  assign {m_rs_data, m_rt_data, m_imm, m_rs, m_rt, m_alu_src, m_alu_control} = main_q;
  assign load = in_valid && in_ready;

`ifdef ID_EX_SKID_EN
  logic [ENT_W-1:0] skid_q, skid_d;
  logic             skid_valid_q, skid_valid_d;

  assign in_ready = !skid_valid_q;

  // The skid entry only fills while main is held, so it always drains first.
  always_comb begin
    main_d       = main_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (load) begin
        main_d      = in_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (load) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    main_d      = main_q;
    out_valid_d = out_valid_q;
    if (load) begin
      main_d      = in_entry;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (flush) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  // Clearing main_q also leaves alu_control at AND (000).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      main_q      <= main_d;
      out_valid_q <= out_valid_d;
    end
  end

  logic [REG_ADDR_W-1:0] fwd_addr [2];
  logic [DATA_W-1:0]     fwd_held [2];
  logic [DATA_W-1:0]     fwd_data [2];

  assign fwd_addr[0] = m_rs;
  assign fwd_addr[1] = m_rt;
  assign fwd_held[0] = m_rs_data;
  assign fwd_held[1] = m_rt_data;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    fwd_mux #(
      .FWD_DATA_W (DATA_W),
      .FWD_ADDR_W (REG_ADDR_W)
    ) u_fwd_mux (
      .src_addr_i      (fwd_addr[gi]),
      .held_data_i     (fwd_held[gi]),
      .exm_reg_write_i (exm_reg_write),
      .exm_write_reg_i (exm_write_reg),
      .exm_result_i    (exm_result),
      .wb_reg_write_i  (wb_reg_write),
      .wb_write_reg_i  (wb_write_reg),
      .wb_result_i     (wb_result),
      .fwd_data_o      (fwd_data[gi])
    );
  end

  assign out_valid   = out_valid_q;
  assign num1        = fwd_data[0];
  assign num2        = m_alu_src ? m_imm : fwd_data[1];
  assign store_data  = fwd_data[1];
  assign alu_control = m_alu_control;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with an input-record scoreboard; expected operands are
// derived from the forwarding inputs present when each record reaches the ALU.
module tb_id_ex_stage;

`ifdef ID_EX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, in_ready;
  logic [31:0] in_rs_data, in_rt_data, in_imm;
  logic [4:0]  in_rs, in_rt;
  logic        in_alu_src;
  logic [2:0]  in_alu_control;
  logic        exm_reg_write, wb_reg_write;
  logic [4:0]  exm_write_reg, wb_write_reg;
  logic [31:0] exm_result, wb_result;
  logic        out_valid, out_ready;
  logic [31:0] num1, num2, store_data;
  logic [2:0]  alu_control;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_rs(in_rs), .in_rt(in_rt), .in_alu_src(in_alu_src), .in_alu_control(in_alu_control),
    .exm_reg_write(exm_reg_write), .exm_write_reg(exm_write_reg), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_result(wb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .num1(num1), .num2(num2), .alu_control(alu_control), .store_data(store_data)
  );

  typedef struct {
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        src;
    logic [2:0]  ctrl;
  } rec_t;

  rec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd_model(input logic [4:0] a, input logic [31:0] d);
    if (exm_reg_write && exm_write_reg != 5'd0 && exm_write_reg == a) return exm_result;
    if (wb_reg_write && wb_write_reg != 5'd0 && wb_write_reg == a) return wb_result;
    return d;
  endfunction

  // Book-keeps this cycle's handshakes, then advances to one unit after the next edge.
  task automatic cycle();
    rec_t        r;
    logic [31:0] ea, eb;
    #1;
    if (out_valid && out_ready) begin
      chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        r  = sb.pop_front();
        ea = fwd_model(r.rs, r.rs_data);
        eb = fwd_model(r.rt, r.rt_data);
        chk("num1", num1, ea);
        chk("num2", num2, r.src ? r.imm : eb);
        chk("alu_control", {29'b0, alu_control}, {29'b0, r.ctrl});
        chk("store_data", store_data, eb);
        $display("txn out: num1=%h num2=%h ctrl=%b store=%h", num1, num2, alu_control, store_data);
      end
    end
    if (flush) begin
      sb.delete();
    end else if (in_valid && in_ready) begin
      r = '{in_rs_data, in_rt_data, in_imm, in_rs, in_rt, in_alu_src, in_alu_control};
      sb.push_back(r);
      $display("txn in : rs=%0d rt=%0d rs_data=%h rt_data=%h imm=%h src=%b ctrl=%b",
               in_rs, in_rt, in_rs_data, in_rt_data, in_imm, in_alu_src, in_alu_control);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [4:0] s, input logic [4:0] t, input logic src,
                       input logic [2:0] c);
    in_rs_data = a; in_rt_data = b; in_imm = im;
    in_rs = s; in_rt = t; in_alu_src = src; in_alu_control = c;
    in_valid = 1'b1;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] ea, input logic [31:0] er,
                         input logic ww, input logic [4:0] wa, input logic [31:0] wr);
    exm_reg_write = ew; exm_write_reg = ea; exm_result = er;
    wb_reg_write  = ww; wb_write_reg  = wa; wb_result  = wr;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && sb.size() > 0; i++) cycle();
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 3'b000);
    in_valid = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);

    // reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_control", alu_control, 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // passthrough, register operands
    drive(32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 1'b0, 3'b010);
    cycle();
    in_valid = 1'b0;
    chk("latency_valid", out_valid, 1);
    chk("pass_num1", num1, 32'd5);
    chk("pass_num2", num2, 32'd7);
    drain();

    // passthrough, immediate operand B
    drive(32'd5, 32'd7, 32'hFFFF_FFFC, 5'd1, 5'd2, 1'b1, 3'b010);
    cycle();
    in_valid = 1'b0;
    chk("imm_num2", num2, 32'hFFFF_FFFC);
    drain();

    // forwarding priority: EX/MEM over MEM/WB
    set_fwd(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
    drive(32'h99, 32'h55, 32'd0, 5'd3, 5'd6, 1'b0, 3'b110);
    cycle();
    in_valid = 1'b0;
    chk("fwd_exm", num1, 32'h11);
    drain();

    exm_reg_write = 1'b0;
    drive(32'h99, 32'h55, 32'd0, 5'd3, 5'd6, 1'b0, 3'b110);
    cycle();
    in_valid = 1'b0;
    chk("fwd_wb", num1, 32'h22);
    drain();

    // register 0 never forwarded
    set_fwd(1, 5'd0, 32'h11, 1, 5'd0, 32'h22);
    drive(32'h77, 32'h66, 32'd0, 5'd0, 5'd0, 1'b0, 3'b001);
    cycle();
    in_valid = 1'b0;
    chk("r0_num1", num1, 32'h77);
    chk("r0_store", store_data, 32'h66);
    drain();
    set_fwd(0, 0, 0, 0, 0, 0);

    // backpressure: A held for 3 cycles while B is offered
    out_ready = 1'b0;
    drive(32'h100, 32'h200, 32'd0, 5'd7, 5'd8, 1'b0, 3'b111);
    cycle();
    drive(32'h300, 32'h400, 32'h10, 5'd9, 5'd10, 1'b1, 3'b000);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_num1", num1, 32'h100);
      chk("hold_num2", num2, 32'h200);
      chk("hold_ctrl", alu_control, 3'b111);
      chk("hold_in_ready", in_ready, (SKID && i == 0) ? 32'd1 : 32'd0);
      cycle();
    end
    chk("hold_accepted", sb.size(), SKID ? 32'd2 : 32'd1);
    in_valid  = !SKID;
    out_ready = 1'b1;
    cycle();
    drain();

    // flush beats a simultaneous load
    out_ready = 1'b1;
    flush = 1'b1;
    drive(32'hDEAD, 32'hBEEF, 32'd0, 5'd12, 5'd13, 1'b0, 3'b010);
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    drive(32'h1234, 32'h5678, 32'd0, 5'd14, 5'd15, 1'b0, 3'b110);
    cycle();
    in_valid = 1'b0;
    chk("post_flush_valid", out_valid, 1);
    drain();

    // stalled instruction picks up a later writeback on rt
    out_ready = 1'b0;
    drive(32'h10, 32'h1111, 32'd0, 5'd11, 5'd4, 1'b0, 3'b010);
    cycle();
    in_valid = 1'b0;
    chk("stall_pre_store", store_data, 32'h1111);
    set_fwd(0, 0, 0, 1, 5'd4, 32'hABCD);
    #1;
    chk("stall_store", store_data, 32'hABCD);
    chk("stall_num2", num2, 32'hABCD);
    cycle();
    chk("stall_store_held", store_data, 32'hABCD);
    drain();
    set_fwd(0, 0, 0, 0, 0, 0);

    // asynchronous reset while holding a valid instruction
    out_ready = 1'b0;
    drive(32'h42, 32'h43, 32'd0, 5'd16, 5'd17, 1'b0, 3'b110);
    cycle();
    in_valid = 1'b0;
    chk("pre_reset_valid", out_valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ctrl", alu_control, 0);
    sb.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
